// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential single-precision divider.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fp_div_pkg;

    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;
    localparam int BIAS   = 127;
    localparam int QBITS  = 26;

    localparam logic [31:0]      QNAN      = 32'h7FC0_0000;
    localparam logic [30:0]      INF       = 31'h7F80_0000;
    localparam logic [EXP_W-1:0] EXP_ONES  = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_ZERO  = 8'h00;
    localparam logic signed [9:0] EXP_OVF  = 10'sd255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIVIDE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    // Exponent zero counts as zero: denormals are flushed.
    function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                           input logic [MANT_W-1:0] m);
        fp_class_t c;
        c.zero = (e == EXP_ZERO);
        c.inf  = (e == EXP_ONES) && (m == '0);
        c.nan  = (e == EXP_ONES) && (m != '0);
        return c;
    endfunction

endpackage

// File: rtl/mant_div_step.sv
// One restoring radix-2 division step on the 24-bit significands.
// Latency: combinational.
// Backpressure: none; iterated by the parent FSM.
module mant_div_step (
    input  logic [24:0] rem,
    input  logic [23:0] den,
    output logic [24:0] rem_next,
    output logic        qbit
);
    logic [23:0] diff;

    // When rem >= den the true difference is below den, so 24 bits hold it exactly.
    assign qbit     = (rem >= {1'b0, den});
    assign diff     = rem[23:0] - den;
    assign rem_next = qbit ? {diff, 1'b0} : {rem[23:0], 1'b0};

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider, one quotient bit per cycle.
// Latency: Done 30 cycles after the Start edge on the normal path, 2 on special operands.
// Backpressure: Start ignored while Busy; result held until the next accepted Start.
module fp_divider_seq
    import fp_div_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Out,
    output logic        Over,
    output logic        Under,
    output logic        DivZero,
    output logic        Invalid
);
    state_t state, next_state;

    logic [31:0]        a_q, b_q;
    logic               sign_q;
    logic [24:0]        rem_q;
    logic [23:0]        den_q;
    logic [QBITS-1:0]   q_q;
    logic [4:0]         cnt_q;
    logic signed [9:0]  exp_q;
    logic [MANT_W-1:0]  frac_q;
    logic               guard_q, sticky_q;
    logic [31:0]        out_q;
    logic               over_q, under_q, divzero_q, invalid_q;

    fp_class_t ca, cb;
    logic      sign_c, inval_c, special_c;

    assign ca        = classify(a_q[30:23], a_q[22:0]);
    assign cb        = classify(b_q[30:23], b_q[22:0]);
    assign sign_c    = a_q[31] ^ b_q[31];
    assign inval_c   = ca.nan | cb.nan | (ca.zero & cb.zero) | (ca.inf & cb.inf);
    assign special_c = inval_c | ca.inf | cb.zero | ca.zero | cb.inf;

    logic [24:0] rem_next;
    logic        qbit;

    mant_div_step u_step (
        .rem      (rem_q),
        .den      (den_q),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Rounding works on the fraction only; the hidden bit is always 1 after NORM,
    // so a carry out of the fraction means the significand became 2.0.
    logic              round_up;
    logic [MANT_W:0]   frac_inc;
    logic signed [9:0] exp_r;

    assign round_up = guard_q & (sticky_q | frac_q[0]);
    assign frac_inc = {1'b0, frac_q} + {{MANT_W{1'b0}}, round_up};
    assign exp_r    = exp_q + {9'b0, frac_inc[MANT_W]};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (Start) next_state = S_CHECK;
            S_CHECK:  next_state = special_c ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (cnt_q == 5'(QBITS - 1)) next_state = S_NORM;
            S_NORM:   next_state = S_ROUND;
            S_ROUND:  next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            rem_q     <= '0;
            den_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            frac_q    <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            out_q     <= '0;
            over_q    <= 1'b0;
            under_q   <= 1'b0;
            divzero_q <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        a_q       <= Dividend;
                        b_q       <= Divisor;
                        over_q    <= 1'b0;
                        under_q   <= 1'b0;
                        divzero_q <= 1'b0;
                        invalid_q <= 1'b0;
                    end
                end
                S_CHECK: begin
                    sign_q <= sign_c;
                    if (inval_c) begin
                        out_q     <= QNAN;
                        invalid_q <= 1'b1;
                    end else if (ca.inf) begin
                        out_q <= {sign_c, INF};
                    end else if (cb.zero) begin
                        out_q     <= {sign_c, INF};
                        divzero_q <= 1'b1;
                    end else if (ca.zero | cb.inf) begin
                        out_q <= {sign_c, 31'b0};
                    end else begin
                        rem_q <= {2'b01, a_q[22:0]};
                        den_q <= {1'b1, b_q[22:0]};
                        exp_q <= {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'(BIAS);
                        cnt_q <= '0;
                        q_q   <= '0;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_next;
                    q_q   <= {q_q[QBITS-2:0], qbit};
                    cnt_q <= cnt_q + 5'd1;
                end
                S_NORM: begin
                    if (q_q[25]) begin
                        frac_q   <= q_q[24:2];
                        guard_q  <= q_q[1];
                        sticky_q <= q_q[0] | (|rem_q);
                    end else begin
                        frac_q   <= q_q[23:1];
                        guard_q  <= q_q[0];
                        sticky_q <= |rem_q;
                        exp_q    <= exp_q - 10'sd1;
                    end
                end
                S_ROUND: begin
                    if (exp_r >= EXP_OVF) begin
                        out_q  <= {sign_q, INF};
                        over_q <= 1'b1;
                    end else if (exp_r <= 10'sd0) begin
                        out_q   <= {sign_q, 31'b0};
                        under_q <= 1'b1;
                    end else begin
                        out_q <= {sign_q, exp_r[7:0], frac_inc[MANT_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy    = (state != S_IDLE) && (state != S_DONE);
    assign Done    = (state == S_DONE);
    assign Out     = out_q;
    assign Over    = over_q;
    assign Under   = under_q;
    assign DivZero = divzero_q;
    assign Invalid = invalid_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Table-driven bench for fp_divider_seq with a result scoreboard and
// hand-written sequences for Start-while-busy and mid-operation reset.
module tb_fp_divider_seq;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] Dividend, Divisor;
    logic        Busy, Done, Over, Under, DivZero, Invalid;
    logic [31:0] Out;

    fp_divider_seq dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Busy     (Busy),
        .Done     (Done),
        .Out      (Out),
        .Over     (Over),
        .Under    (Under),
        .DivZero  (DivZero),
        .Invalid  (Invalid)
    );

    always #5 CLK = ~CLK;

    // flags = {Over, Under, DivZero, Invalid}
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];
    exp_t sb [$];

    int n_vec   = 0;
    int n_check = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_check++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Waits until the DUT is back in IDLE, then presents one request at a negedge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_out, input logic [3:0] e_flags,
                          input int e_lat, input bit track);
        exp_t e;
        @(posedge CLK);
        @(negedge CLK);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        n_vec++;
        if (track) begin
            e.out = e_out; e.flags = e_flags; e.lat = e_lat;
            sb.push_back(e);
        end
    endtask

    // Counts cycles from the accepting edge (cycle 1) until Done; optionally pulses
    // a spurious Start with different operands at cycle spur.
    task automatic collect(input string name, input int spur);
        exp_t e;
        bit   seen    = 1'b0;
        bit   busy_ok = 1'b1;
        int   cyc     = 0;
        e = sb.pop_front();
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge CLK);
            #1;
            if (c == 1) Start = 1'b0;
            if (spur != 0 && c == spur) begin
                Start    = 1'b1;
                Dividend = 32'h3F80_0000;
                Divisor  = 32'h0000_0000;
            end
            if (spur != 0 && c == spur + 1) Start = 1'b0;
            if (Done) begin
                seen = 1'b1;
                cyc  = c;
                if (Busy !== 1'b0) busy_ok = 1'b0;
            end else if (Busy !== (c < e.lat)) begin
                busy_ok = 1'b0;
            end
        end
        if (!seen) begin
            n_check++;
            n_fail++;
            $display("FAIL %s timeout: no Done within 40 cycles, expected at cycle %0d", name, e.lat);
        end else begin
            check({name, " out"},     Out, e.out);
            check({name, " flags"},   {28'b0, Over, Under, DivZero, Invalid}, {28'b0, e.flags});
            check({name, " latency"}, cyc, e.lat);
            check({name, " busy"},    {31'b0, busy_ok}, 32'd1);
        end
    endtask

    task automatic check_idle_zero(input string name);
        check({name, " out"},  Out, 32'h0);
        check({name, " ctl"},  {30'b0, Busy, Done}, 32'h0);
        check({name, " flags"}, {28'b0, Over, Under, DivZero, Invalid}, 32'h0);
    endtask

    initial begin
        Reset    = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;

        vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 30};
        vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 30};
        vecs[2]  = '{32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 4'b0000, 30};
        vecs[3]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0010, 2};
        vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001, 2};
        vecs[5]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b1000, 30};
        vecs[6]  = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100, 30};
        vecs[7]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0001, 2};
        vecs[8]  = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b0001, 2};
        vecs[9]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 2};
        vecs[10] = '{32'h4000_0000, 32'h8000_0000, 32'hFF80_0000, 4'b0010, 2};
        vecs[11] = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 4'b0000, 2};
        vecs[12] = '{32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 4'b0000, 2};
        vecs[13] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 30};
        vecs[14] = '{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 30};
        vecs[15] = '{32'h3F80_0000, 32'hFF80_0001, 32'h7FC0_0000, 4'b0001, 2};
        vecs[16] = '{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0000, 2};
        vecs[17] = '{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 2};

        #12;
        check_idle_zero("reset");
        @(negedge CLK);
        Reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].flags, vecs[i].lat, 1'b1);
            collect($sformatf("vec%0d", i), 0);
        end

        // Start while busy must not disturb the running divide.
        launch(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 30, 1'b1);
        collect("start_busy", 10);

        // Reset partway through a divide abandons it and clears every output.
        launch(32'h3F80_0000, 32'h4040_0000, 32'h0, 4'b0000, 0, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            @(posedge CLK);
            #1;
            if (c == 1) Start = 1'b0;
        end
        check("pre_reset busy", {31'b0, Busy}, 32'd1);
        Reset = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        check_idle_zero("post_reset");

        launch(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 30, 1'b1);
        collect("after_reset", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
